// File: rtl/fetch_sequencer_if.sv
// Handshake and status bundle between the fetch sequencer and the core/memory side.
// The master modport is the sequencer; the slave modport is the memory bus / datapath.
interface fetch_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic             instr_load;
    logic             dmem_req;
    logic             dmem_ack;
    logic             mem_op;
    logic             halt_req;
    logic             pc_en;
    logic             halted;
    logic             bus_fault;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output imem_req,
        output instr_load,
        output dmem_req,
        output pc_en,
        output halted,
        output bus_fault,
        output retire_count,
        input  imem_ack,
        input  dmem_ack,
        input  mem_op,
        input  halt_req
    );

    modport slave (
        input  imem_req,
        input  instr_load,
        input  dmem_req,
        input  pc_en,
        input  halted,
        input  bus_fault,
        input  retire_count,
        output imem_ack,
        output dmem_ack,
        output mem_op,
        output halt_req
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Control FSM sequencing PC updates against instruction/data memory handshakes,
// with halt support, acknowledge-timeout fault detection and a retired-instruction counter.
module fetch_sequencer #(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    fetch_sequencer_if.master io_seq
);
    localparam int                WAIT_W     = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_retire_count;

    logic w_imem_req;
    logic w_instr_load;
    logic w_dmem_req;
    logic w_pc_en;
    logic w_halted;
    logic w_bus_fault;
    logic w_wait_expired;

    // Outputs decode straight from state so that an asynchronous reset drops requests at once.
    always_comb begin
        w_imem_req   = 1'b0;
        w_instr_load = 1'b0;
        w_dmem_req   = 1'b0;
        w_pc_en      = 1'b0;
        w_halted     = 1'b0;
        w_bus_fault  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req   = 1'b1;
                w_instr_load = io_seq.imem_ack;
            end
            S_EXEC: begin
                w_pc_en = ~io_seq.halt_req & ~io_seq.mem_op;
            end
            S_MEM: begin
                w_dmem_req = 1'b1;
                w_pc_en    = io_seq.dmem_ack;
            end
            S_HALTED: w_halted    = 1'b1;
            S_FAULT:  w_bus_fault = 1'b1;
            default: ;
        endcase
    end

    assign w_wait_expired = (r_wait_cnt == WAIT_LIMIT);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state        <= S_IDLE;
            r_wait_cnt     <= '0;
            r_retire_count <= '0;
        end else begin
            if (w_pc_en) begin
                r_retire_count <= r_retire_count + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_FETCH;
                    r_wait_cnt <= '0;
                end
                S_FETCH: begin
                    // An ack in the limit cycle still completes the fetch normally.
                    if (io_seq.imem_ack) begin
                        r_state <= S_EXEC;
                    end else if (w_wait_expired) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_EXEC: begin
                    r_wait_cnt <= '0;
                    if (io_seq.halt_req) begin
                        r_state <= S_HALTED;
                    end else if (io_seq.mem_op) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (io_seq.dmem_ack) begin
                        r_state    <= S_FETCH;
                        r_wait_cnt <= '0;
                    end else if (w_wait_expired) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_HALTED: r_state <= S_HALTED;
                S_FAULT:  r_state <= S_FAULT;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign io_seq.imem_req     = w_imem_req;
    assign io_seq.instr_load   = w_instr_load;
    assign io_seq.dmem_req     = w_dmem_req;
    assign io_seq.pc_en        = w_pc_en;
    assign io_seq.halted       = w_halted;
    assign io_seq.bus_fault    = w_bus_fault;
    assign io_seq.retire_count = r_retire_count;
endmodule
